// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encoding, default timing and sequencer state types for the ALU issue stage
package alu_pkg;

    localparam int ALU_DATA_W  = 8;
    localparam int ALU_LAT     = 1;
    localparam int ALU_MUL_LAT = 2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_DIV  = 4'd3,
        ALU_LSL  = 4'd4,
        ALU_LSR  = 4'd5,
        ALU_ROL  = 4'd6,
        ALU_ROR  = 4'd7,
        ALU_AND  = 4'd8,
        ALU_OR   = 4'd9,
        ALU_XOR  = 4'd10,
        ALU_NOR  = 4'd11,
        ALU_NAND = 4'd12,
        ALU_XNOR = 4'd13,
        ALU_GT   = 4'd14,
        ALU_EQ   = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_e;

    function automatic int unsigned op_latency(
        input alu_op_e     op,
        input int unsigned lat     = ALU_LAT,
        input int unsigned mul_lat = ALU_MUL_LAT
    );
        return (op == ALU_MUL) ? mul_lat : lat;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous show-ahead command FIFO with full/empty flags
module alu_cmd_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues ALU commands, issues them one at a time and returns results in order
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int DEPTH   = 4,
    parameter int LAT     = ALU_LAT,
    parameter int MUL_LAT = ALU_MUL_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Cmd_Valid,
    output logic              Cmd_Ready,
    input  logic [DATA_W-1:0] Cmd_A,
    input  logic [DATA_W-1:0] Cmd_B,
    input  logic [3:0]        Cmd_Sel,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [3:0]        ALU_Sel,
    input  logic [DATA_W-1:0] ALU_Out,
    input  logic              CarryOut,
    output logic              Res_Valid,
    input  logic              Res_Ready,
    output logic [DATA_W-1:0] Res_Data,
    output logic              Res_Carry,
    output logic [3:0]        Res_Sel,
    output logic              Res_Err,
    output logic              Busy
);

    localparam int FW    = 2 * DATA_W + 4;
    localparam int CNT_W = $clog2(MUL_LAT) + 1;

    logic [FW-1:0]     head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    seq_state_e        state_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    alu_op_e           sel_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_carry_q;
    alu_op_e           res_sel_q;
    logic              res_err_q;

    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

    alu_cmd_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (Cmd_Valid),
        .wdata_i ({Cmd_Sel, Cmd_A, Cmd_B}),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= ALU_ADD;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_sel_q   <= ALU_ADD;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        sel_q   <= alu_op_e'(head[FW-1 -: 4]);
                        a_q     <= head[2*DATA_W-1 -: DATA_W];
                        b_q     <= head[DATA_W-1:0];
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Divide by zero is answered locally; the ALU output is never looked at.
                    if (sel_q == ALU_DIV && b_q == '0) begin
                        res_data_q  <= '1;
                        res_carry_q <= 1'b0;
                        res_err_q   <= 1'b1;
                        res_sel_q   <= sel_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else begin
                        cnt_q   <= CNT_W'(op_latency(sel_q, LAT, MUL_LAT) - 1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        res_data_q  <= ALU_Out;
                        res_carry_q <= (sel_q == ALU_ADD) ? CarryOut : 1'b0;
                        res_err_q   <= 1'b0;
                        res_sel_q   <= sel_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (Res_Ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Cmd_Ready = !fifo_full;
    assign A         = a_q;
    assign B         = b_q;
    assign ALU_Sel   = sel_q;
    assign Res_Valid = res_valid_q;
    assign Res_Data  = res_data_q;
    assign Res_Carry = res_carry_q;
    assign Res_Sel   = res_sel_q;
    assign Res_Err   = res_err_q;
    assign Busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed bench for alu_cmd_sequencer with a registered 8-bit ALU behind it
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       Cmd_Valid;
    logic       Cmd_Ready;
    logic [7:0] Cmd_A;
    logic [7:0] Cmd_B;
    logic [3:0] Cmd_Sel;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic [7:0] ALU_Out;
    logic       CarryOut;
    logic       Res_Valid;
    logic       Res_Ready;
    logic [7:0] Res_Data;
    logic       Res_Carry;
    logic [3:0] Res_Sel;
    logic       Res_Err;
    logic       Busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .Cmd_Valid (Cmd_Valid),
        .Cmd_Ready (Cmd_Ready),
        .Cmd_A     (Cmd_A),
        .Cmd_B     (Cmd_B),
        .Cmd_Sel   (Cmd_Sel),
        .A         (A),
        .B         (B),
        .ALU_Sel   (ALU_Sel),
        .ALU_Out   (ALU_Out),
        .CarryOut  (CarryOut),
        .Res_Valid (Res_Valid),
        .Res_Ready (Res_Ready),
        .Res_Data  (Res_Data),
        .Res_Carry (Res_Carry),
        .Res_Sel   (Res_Sel),
        .Res_Err   (Res_Err),
        .Busy      (Busy)
    );

    // ALU model: carry is the add carry for every op, so the sequencer must mask it.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        logic [8:0]  sum;
        logic [15:0] prod;
        logic [7:0]  r;
        sum  = {1'b0, a} + {1'b0, b};
        prod = a * b;
        case (sel)
            4'd0:    r = sum[7:0];
            4'd1:    r = a - b;
            4'd2:    r = prod[7:0];
            4'd3:    r = (b == 8'd0) ? 8'h00 : a / b;
            4'd4:    r = a << 1;
            4'd5:    r = a >> 1;
            4'd6:    r = {a[6:0], a[7]};
            4'd7:    r = {a[0], a[7:1]};
            4'd8:    r = a & b;
            4'd9:    r = a | b;
            4'd10:   r = a ^ b;
            4'd11:   r = ~(a | b);
            4'd12:   r = ~(a & b);
            4'd13:   r = ~(a ^ b);
            4'd14:   r = (a > b) ? 8'd1 : 8'd0;
            default: r = (a == b) ? 8'd1 : 8'd0;
        endcase
        return {sum[8], r};
    endfunction

    logic [8:0] s1;
    logic [8:0] s2;
    always @(posedge clk) begin
        s1 <= alu_f(A, B, ALU_Sel);
        s2 <= s1;
    end
    assign {CarryOut, ALU_Out} = (ALU_Sel == 4'd2) ? s2 : s1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        @(negedge clk);
        Cmd_A     = a;
        Cmd_B     = b;
        Cmd_Sel   = sel;
        Cmd_Valid = 1'b1;
        for (int i = 0; i < 50 && !Cmd_Ready; i++) @(negedge clk);
        check("cmd_ready_at_accept", Cmd_Ready, 1);
        @(posedge clk);
        #1;
        Cmd_Valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (Res_Valid) break;
        end
        if (!Res_Valid) check("res_valid_timeout", Res_Valid, 1);
    endtask

    task automatic collect(input string nm, input logic [7:0] exp_d, input logic [3:0] exp_s, input logic exp_e);
        int cyc;
        wait_result(cyc);
        check({nm, "_data"}, Res_Data, exp_d);
        check({nm, "_sel"}, Res_Sel, exp_s);
        check({nm, "_err"}, Res_Err, exp_e);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_window(input string nm, input int n);
        bit seen_valid;
        bit seen_busy;
        seen_valid = 1'b0;
        seen_busy  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (Res_Valid) seen_valid = 1'b1;
            if (Busy) seen_busy = 1'b1;
        end
        check({nm, "_no_extra_result"}, seen_valid, 0);
        check({nm, "_idle"}, seen_busy, 0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] exp_data;
        logic       exp_carry;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         cyc;
        logic       rdy[5];
        int         n_acc;
        logic [7:0] ta[5];
        logic [7:0] tb[5];
        logic [3:0] ts[5];

        vecs[0] = '{8'd200, 8'd100, 4'd0,  8'd44,  1'b1, 1'b0, 3};
        vecs[1] = '{8'd15,  8'd17,  4'd2,  8'd255, 1'b0, 1'b0, 4};
        vecs[2] = '{8'd9,   8'd0,   4'd3,  8'hFF,  1'b0, 1'b1, 2};
        vecs[3] = '{8'd9,   8'd3,   4'd3,  8'd3,   1'b0, 1'b0, 3};
        vecs[4] = '{8'd200, 8'd100, 4'd1,  8'd100, 1'b0, 1'b0, 3};
        vecs[5] = '{8'hF0,  8'h3C,  4'd10, 8'hCC,  1'b0, 1'b0, 3};
        vecs[6] = '{8'h81,  8'h00,  4'd6,  8'h03,  1'b0, 1'b0, 3};
        vecs[7] = '{8'd12,  8'd12,  4'd15, 8'd1,   1'b0, 1'b0, 3};
        vecs[8] = '{8'd16,  8'd16,  4'd2,  8'd0,   1'b0, 1'b0, 4};

        rst       = 1'b1;
        Cmd_Valid = 1'b0;
        Cmd_A     = '0;
        Cmd_B     = '0;
        Cmd_Sel   = '0;
        Res_Ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", Cmd_Ready, 1);
        check("rst_res_valid", Res_Valid, 0);
        check("rst_busy", Busy, 0);
        check("rst_outputs", {A, B, ALU_Sel, Res_Data, Res_Carry, Res_Sel, Res_Err}, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            send_cmd(vecs[i].a, vecs[i].b, vecs[i].sel);
            wait_result(cyc);
            check($sformatf("v%0d_latency", i), cyc, vecs[i].exp_lat);
            check($sformatf("v%0d_data", i), Res_Data, vecs[i].exp_data);
            check($sformatf("v%0d_carry", i), Res_Carry, vecs[i].exp_carry);
            check($sformatf("v%0d_err", i), Res_Err, vecs[i].exp_err);
            check($sformatf("v%0d_res_sel", i), Res_Sel, vecs[i].sel);
            check($sformatf("v%0d_alu_sel", i), ALU_Sel, vecs[i].sel);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid_drops", i), Res_Valid, 0);
        end

        // Back-pressure: one result held, then five pushes against a four-deep queue.
        ta = '{8'd10, 8'd7, 8'hAA, 8'd50, 8'd1};
        tb = '{8'd20, 8'd6, 8'h0F, 8'd0,  8'd1};
        ts = '{4'd0,  4'd2, 4'd8,  4'd3,  4'd0};
        Res_Ready = 1'b0;
        send_cmd(8'd1, 8'd2, 4'd0);
        wait_result(cyc);
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            Cmd_A     = ta[i];
            Cmd_B     = tb[i];
            Cmd_Sel   = ts[i];
            Cmd_Valid = 1'b1;
            rdy[i]    = Cmd_Ready;
            @(posedge clk);
            #1;
            if (rdy[i]) n_acc++;
        end
        Cmd_Valid = 1'b0;
        check("bp_accepted", n_acc, 4);
        check("bp_fifth_refused", rdy[4], 0);
        check("bp_held_valid", Res_Valid, 1);
        check("bp_held_data", Res_Data, 3);
        @(negedge clk);
        Res_Ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_held_released", Res_Valid, 0);
        collect("bp_r0", 8'd30,  4'd0, 1'b0);
        collect("bp_r1", 8'd42,  4'd2, 1'b0);
        collect("bp_r2", 8'h0A,  4'd8, 1'b0);
        collect("bp_r3", 8'hFF,  4'd3, 1'b1);
        quiet_window("bp", 12);

        // Simultaneous push and pop with three queued.
        Res_Ready = 1'b0;
        send_cmd(8'd3, 8'd4, 4'd0);
        wait_result(cyc);
        send_cmd(8'd1,  8'd1,  4'd1);
        send_cmd(8'd5,  8'd3,  4'd9);
        send_cmd(8'h0F, 8'h01, 4'd4);
        @(negedge clk);
        check("pp_head_data", Res_Data, 7);
        Res_Ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        Cmd_A     = 8'd2;
        Cmd_B     = 8'd2;
        Cmd_Sel   = 4'd2;
        Cmd_Valid = 1'b1;
        check("pp_ready_before", Cmd_Ready, 1);
        @(posedge clk);
        #1;
        check("pp_ready_after_push_pop", Cmd_Ready, 1);
        @(negedge clk);
        Cmd_A   = 8'd100;
        Cmd_B   = 8'd27;
        Cmd_Sel = 4'd0;
        @(posedge clk);
        #1;
        Cmd_Valid = 1'b0;
        check("pp_full_after_one_more", Cmd_Ready, 0);
        collect("pp_r0", 8'd0,   4'd1, 1'b0);
        collect("pp_r1", 8'd7,   4'd9, 1'b0);
        collect("pp_r2", 8'h1E,  4'd4, 1'b0);
        collect("pp_r3", 8'd4,   4'd2, 1'b0);
        collect("pp_r4", 8'd127, 4'd0, 1'b0);
        quiet_window("pp", 12);

        // Reset while a multiply waits with two commands queued.
        send_cmd(8'd3, 8'd5, 4'd2);
        send_cmd(8'd1, 8'd1, 4'd0);
        send_cmd(8'd2, 8'd2, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_cmd_ready", Cmd_Ready, 1);
        check("mrst_busy", Busy, 0);
        check("mrst_res_valid", Res_Valid, 0);
        check("mrst_outputs", {A, B, ALU_Sel, Res_Data, Res_Carry, Res_Sel, Res_Err}, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet_window("mrst", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
